// File: rtl/led_pkg.sv
// Shared types and helpers for the status LED sequencer: scheduler states,
// requester (mode) encodings and brightness constants.
package led_pkg;

  typedef enum logic [2:0] {
    ST_BREATH,
    ST_ACTIVITY,
    ST_ERR_ON,
    ST_ERR_OFF,
    ST_ERR_GAP
  } state_e;

  typedef enum logic [1:0] {
    MODE_BREATH   = 2'd0,
    MODE_ACTIVITY = 2'd1,
    MODE_ERROR    = 2'd2
  } mode_e;

  localparam logic [7:0] LEVEL_FULL = 8'hFF;
  localparam logic [7:0] LEVEL_OFF  = 8'h00;

  // Counter width for a count of n; a 1-bit floor keeps degenerate sizes legal.
  function automatic int cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic mode_e mode_of(input state_e s);
    case (s)
      ST_ACTIVITY:                     return MODE_ACTIVITY;
      ST_ERR_ON, ST_ERR_OFF, ST_ERR_GAP: return MODE_ERROR;
      default:                         return MODE_BREATH;
    endcase
  endfunction

  // Triangle wave: ramps 0..255 on the lower half, mirrors back down on the upper.
  function automatic logic [7:0] breath_level(input logic [8:0] b);
    return b[7:0] ^ {8{b[8]}};
  endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM brightness engine: free-running 8-bit ramp compared against the
// requested level, with a registered LED drive.
module led_pwm (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] level,
  input  logic       enable,
  output logic       led
);

  logic [7:0] pwm_cnt_q;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= 8'd0;
      led       <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      led       <= enable && (pwm_cnt_q < level);
    end
  end

endmodule

// File: rtl/led_status_sequencer.sv
// Status LED owner: tick divider, breathing counter and the priority scheduler
// that picks which requester (breath / activity / error code) sets the level.
module led_status_sequencer
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 256,
  parameter int unsigned ACT_TICKS     = 64,
  parameter int unsigned ERR_ON_TICKS  = 128,
  parameter int unsigned ERR_GAP_TICKS = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       act_pulse,
  input  logic       err_pulse,
  input  logic [2:0] err_code,
  output logic       led,
  output logic [1:0] mode,
  output logic       busy
);

  localparam int TICK_W  = cnt_width(TICK_DIV);
  localparam int HOLD_W  = cnt_width(ACT_TICKS);
  localparam int PHASE_W = cnt_width((ERR_ON_TICKS > ERR_GAP_TICKS) ? ERR_ON_TICKS
                                                                    : ERR_GAP_TICKS);

  localparam logic [TICK_W-1:0]  TICK_LAST      = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST      = HOLD_W'(ACT_TICKS - 1);
  localparam logic [PHASE_W-1:0] PHASE_ON_LAST  = PHASE_W'(ERR_ON_TICKS - 1);
  localparam logic [PHASE_W-1:0] PHASE_GAP_LAST = PHASE_W'(ERR_GAP_TICKS - 1);

  state_e             state_q,      state_d;
  logic [TICK_W-1:0]  tick_cnt_q;
  logic [8:0]         breath_cnt_q;
  logic [HOLD_W-1:0]  hold_q,       hold_d;
  logic [PHASE_W-1:0] phase_q,      phase_d;
  logic [2:0]         flashes_q,    flashes_d;
  logic               pend_valid_q, pend_valid_d;
  logic [2:0]         pend_code_q,  pend_code_d;
  logic [7:0]         level_q,      level_d;

  logic       tick;
  logic [2:0] code_eff;

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign code_eff = (err_code == 3'd0) ? 3'd1 : err_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      breath_cnt_q <= '0;
      state_q      <= ST_BREATH;
      hold_q       <= '0;
      phase_q      <= '0;
      flashes_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      level_q      <= LEVEL_OFF;
    end else begin
      tick_cnt_q   <= tick ? '0 : tick_cnt_q + 1'b1;
      // Breathing only advances while it actually owns the LED.
      if (tick && enable && state_q == ST_BREATH) breath_cnt_q <= breath_cnt_q + 9'd1;
      state_q      <= state_d;
      hold_q       <= hold_d;
      phase_q      <= phase_d;
      flashes_q    <= flashes_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      level_q      <= level_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    phase_d      = phase_q;
    flashes_d    = flashes_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;

    if (!enable) begin
      state_d      = ST_BREATH;
      pend_valid_d = 1'b0;
      hold_d       = '0;
      phase_d      = '0;
    end else begin
      case (state_q)
        ST_BREATH, ST_ACTIVITY: begin
          if (err_pulse) begin
            flashes_d = code_eff;
            phase_d   = '0;
            state_d   = ST_ERR_ON;
          end else if (act_pulse) begin
            hold_d  = '0;
            state_d = ST_ACTIVITY;
          end else if (state_q == ST_ACTIVITY && tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              state_d = ST_BREATH;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        ST_ERR_ON: begin
          if (tick) begin
            if (phase_q == PHASE_ON_LAST) begin
              phase_d   = '0;
              flashes_d = flashes_q - 3'd1;
              state_d   = ST_ERR_OFF;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        ST_ERR_OFF: begin
          if (tick) begin
            if (phase_q == PHASE_ON_LAST) begin
              phase_d = '0;
              state_d = (flashes_q != 3'd0) ? ST_ERR_ON : ST_ERR_GAP;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        ST_ERR_GAP: begin
          if (tick) begin
            if (phase_q == PHASE_GAP_LAST) begin
              phase_d = '0;
              if (pend_valid_q) begin
                flashes_d    = pend_code_q;
                pend_valid_d = 1'b0;
                state_d      = ST_ERR_ON;
              end else begin
                state_d = ST_BREATH;
              end
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        default: state_d = ST_BREATH;
      endcase

      // Applied last so a strobe on the gap exit replaces, rather than feeds, the reload.
      if (err_pulse && state_q inside {ST_ERR_ON, ST_ERR_OFF, ST_ERR_GAP}) begin
        pend_valid_d = 1'b1;
        pend_code_d  = code_eff;
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_BREATH:              level_d = breath_level(breath_cnt_q);
      ST_ACTIVITY, ST_ERR_ON: level_d = LEVEL_FULL;
      default:                level_d = LEVEL_OFF;
    endcase
  end

  assign mode = mode_of(state_q);
  assign busy = (state_q != ST_BREATH);

  led_pwm u_pwm (
    .clk    (clk),
    .reset  (reset),
    .level  (level_q),
    .enable (enable),
    .led    (led)
  );

endmodule

// File: tb/tb_led_status_sequencer.sv
// Bench for led_status_sequencer: a segment-queue reference model predicts
// led/mode/busy every cycle; directed scenarios pin timing with literal values.
module tb_led_status_sequencer;

  localparam int TICK_DIV      = 4;
  localparam int ACT_TICKS     = 4;
  localparam int ERR_ON_TICKS  = 2;
  localparam int ERR_GAP_TICKS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       act_pulse;
  logic       err_pulse;
  logic [2:0] err_code;
  logic       led;
  logic [1:0] mode;
  logic       busy;

  always #5 clk = ~clk;

  led_status_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .ACT_TICKS     (ACT_TICKS),
    .ERR_ON_TICKS  (ERR_ON_TICKS),
    .ERR_GAP_TICKS (ERR_GAP_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .act_pulse (act_pulse),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .led       (led),
    .mode      (mode),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: the error code is a queue of timed segments; activity
  // is a countdown of remaining ticks; time is a single cycle counter.
  typedef struct {
    bit lit;
    int ticks_left;
  } seg_t;

  int   m_cyc;
  int   m_mode;
  int   m_breath;
  int   m_act_left;
  seg_t m_seq[$];
  bit   m_pend;
  int   m_pend_n;
  int   m_level;
  bit   m_led;

  function automatic int tri_level(input int b);
    return (b < 256) ? b : 511 - b;
  endfunction

  task automatic start_code(input int n);
    m_seq.delete();
    for (int i = 0; i < n; i++) begin
      m_seq.push_back('{lit: 1'b1, ticks_left: ERR_ON_TICKS});
      m_seq.push_back('{lit: 1'b0, ticks_left: ERR_ON_TICKS});
    end
    m_seq.push_back('{lit: 1'b0, ticks_left: ERR_GAP_TICKS});
    m_mode = 2;
  endtask

  task automatic model_advance(input bit rst, input bit en, input bit act,
                               input bit err, input int code);
    bit tick;
    int new_level;
    bit new_led;
    int n_eff;
    if (rst) begin
      m_cyc = 0; m_mode = 0; m_breath = 0; m_act_left = 0;
      m_seq.delete(); m_pend = 0; m_pend_n = 0; m_level = 0; m_led = 0;
      return;
    end
    n_eff     = (code == 0) ? 1 : code;
    tick      = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    new_led   = en && ((m_cyc % 256) < m_level);
    if (m_mode == 0)      new_level = tri_level(m_breath);
    else if (m_mode == 1) new_level = 255;
    else                  new_level = m_seq[0].lit ? 255 : 0;
    if (m_mode == 0 && tick && en) m_breath = (m_breath + 1) % 512;

    if (!en) begin
      m_mode = 0; m_pend = 0; m_seq.delete();
    end else if (m_mode != 2 && err) begin
      start_code(n_eff);
    end else if (m_mode == 2) begin
      if (tick) begin
        m_seq[0].ticks_left--;
        if (m_seq[0].ticks_left == 0) void'(m_seq.pop_front());
        if (m_seq.size() == 0) begin
          if (m_pend) begin
            start_code(m_pend_n);
            m_pend = 0;
          end else begin
            m_mode = 0;
          end
        end
      end
      if (err) begin
        m_pend = 1; m_pend_n = n_eff;
      end
    end else if (act) begin
      m_mode = 1; m_act_left = ACT_TICKS;
    end else if (m_mode == 1 && tick) begin
      m_act_left--;
      if (m_act_left == 0) m_mode = 0;
    end

    m_level = new_level;
    m_led   = new_led;
    m_cyc++;
  endtask

  task automatic compare_outputs();
    check("led",  32'(led),  32'(m_led));
    check("mode", 32'(mode), 32'(m_mode));
    check("busy", 32'(busy), 32'(m_mode != 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_advance(reset, enable, act_pulse, err_pulse, int'(err_code));
    @(negedge clk);
    compare_outputs();
  endtask

  // Position so the next cycle carries a tick; strobes then start on a tick boundary.
  task automatic align_tick();
    while (m_cyc % TICK_DIV != TICK_DIV - 1) step();
  endtask

  task automatic count_busy(output int r);
    r = 0;
    while (busy === 1'b1 && r < 400) begin
      r++;
      step();
    end
  endtask

  task automatic pulse_err(input int code);
    err_pulse = 1'b1;
    err_code  = 3'(code);
    step();
    err_pulse = 1'b0;
  endtask

  task automatic pulse_act();
    act_pulse = 1'b1;
    step();
    act_pulse = 1'b0;
  endtask

  int r;
  int n;

  initial begin
    reset = 1'b1; enable = 1'b1; act_pulse = 1'b0; err_pulse = 1'b0; err_code = 3'd0;
    step();
    step();
    check("rst_led",  32'(led),  0);
    check("rst_mode", 32'(mode), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // Breathing ramp: peak after 255 ticks, then falling.
    for (int i = 0; i < 1100; i++) begin
      step();
      if (m_cyc == 1)    check("model_level_start", 32'(m_level), 0);
      if (m_cyc == 1022) check("model_level_peak",  32'(m_level), 255);
      if (m_cyc == 1040) check("model_level_fall",  32'(m_level), 252);
    end

    // Single activity pulse: 4 ticks of ACTIVITY.
    align_tick();
    pulse_act();
    check("act_mode", 32'(mode), 1);
    check("act_busy", 32'(busy), 1);
    count_busy(r);
    check("act_len", 32'(r), 16);

    // Retrigger two ticks in extends by another 4 ticks.
    align_tick();
    pulse_act();
    repeat (7) step();
    pulse_act();
    count_busy(r);
    check("act_retrig_len", 32'(r), 16);

    // Code 3: 3 x (on+off) + gap = 16 ticks.
    align_tick();
    pulse_err(3);
    check("err3_mode", 32'(mode), 2);
    count_busy(r);
    check("err3_len", 32'(r), 64);

    // Code 0 behaves as one flash.
    align_tick();
    pulse_err(0);
    count_busy(r);
    check("err0_len", 32'(r), 32);

    // Code 2 arriving mid code-3 replays after the gap.
    align_tick();
    pulse_err(3);
    repeat (10) step();
    pulse_err(2);
    count_busy(r);
    check("err_pending_len", 32'(r), 101);

    // Strobe on the gap exit: prior pending reloads, new code waits one more gap.
    align_tick();
    pulse_err(1);
    repeat (4) step();
    pulse_err(1);
    repeat (26) step();
    pulse_err(2);
    count_busy(r);
    check("err_gap_exit_len", 32'(r), 80);

    // Simultaneous strobes: error wins.
    align_tick();
    act_pulse = 1'b1;
    pulse_err(1);
    act_pulse = 1'b0;
    check("both_mode", 32'(mode), 2);
    count_busy(r);
    check("both_len", 32'(r), 32);

    // Disable mid ERR_ON with a pending code: everything cleared.
    align_tick();
    pulse_err(2);
    repeat (2) step();
    pulse_err(3);
    step();
    enable = 1'b0;
    step();
    check("dis_mode", 32'(mode), 0);
    check("dis_busy", 32'(busy), 0);
    step();
    check("dis_led", 32'(led), 0);
    enable = 1'b1;
    n = 0;
    repeat (100) begin
      step();
      if (busy === 1'b1) n++;
    end
    check("reenable_no_pending", 32'(n), 0);

    // Reset in the middle of ACTIVITY.
    pulse_act();
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_act_led",  32'(led),  0);
    check("rst_act_mode", 32'(mode), 0);
    check("rst_act_busy", 32'(busy), 0);
    reset = 1'b0;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (!enable) enable = ($urandom_range(0, 19) == 0);
      else         enable = ($urandom_range(0, 299) != 0);
      act_pulse = ($urandom_range(0, 24) == 0);
      err_pulse = ($urandom_range(0, 59) == 0);
      err_code  = 3'($urandom_range(0, 7));
      reset     = ($urandom_range(0, 1499) == 0);
      step();
    end
    act_pulse = 1'b0; err_pulse = 1'b0; reset = 1'b0; enable = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
